// File: rtl/data_mem_responder.sv
// Word-addressed data memory slave with a fixed per-direction response latency.
// One transaction at a time; completion is a single-cycle active-low dready_n strobe.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 2,
    parameter int WRITE_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dreq,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    inout  wire  [31:0] ddata,
    output logic        dready_n,
    output logic        dbusy,
    output logic        daddr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        READY
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic [3:0]    lat_m1;
    logic          accept;

    logic [AW-1:0] idx_q;
    logic          oob_q;
    logic          wr_q;
    logic [31:0]   wdata_q;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_word;
    logic          drive_en;

    // The byte-lane bits of the address carry no meaning for a word memory.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^daddr[1:0];

    assign lat_m1 = dwrite ? 4'(WRITE_LAT - 1) : 4'(READ_LAT - 1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (dreq) begin
                    accept    = 1'b1;
                    cnt_nxt   = lat_m1;
                    state_nxt = (lat_m1 == 4'd0) ? READY : BUSY;
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    state_nxt = READY;
                end
                cnt_nxt = (cnt == 4'd0) ? 4'd0 : 4'(cnt - 4'd1);
            end
            READY: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request fields are captured once at accept so initiator bus activity afterwards is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            oob_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
        end else if (accept) begin
            idx_q   <= daddr[AW+1:2];
            oob_q   <= |daddr[31:AW+2];
            wr_q    <= dwrite;
            wdata_q <= ddata;
        end
    end

    // Commit happens on the edge that leaves READY; a reset on that edge cancels it.
    always_ff @(posedge clk) begin
        if (!rst && state == READY && wr_q && !oob_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign rd_word   = oob_q ? 32'h0 : mem[idx_q];
    assign drive_en  = (state == READY) && !wr_q;
    assign ddata     = drive_en ? rd_word : 32'bz;

    assign dready_n  = (state != READY);
    assign dbusy     = (state == BUSY);
    assign daddr_err = (state == READY) && oob_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder: two instances with different latencies
// share one reference model style; a negedge monitor pops expected completions from per-instance queues.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    typedef struct {
        int          ready_cyc;
        int          lat;
        bit          is_read;
        bit          known;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dreq      [2];
    logic        dwrite    [2];
    logic [31:0] daddr     [2];
    logic [31:0] drv       [2];
    logic        oe        [2];
    logic        dready_n  [2];
    logic        dbusy     [2];
    logic        daddr_err [2];
    wire  [31:0] bus0;
    wire  [31:0] bus1;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          busy_cnt [2];
    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus0 = oe[0] ? drv[0] : 32'bz;
    assign bus1 = oe[1] ? drv[1] : 32'bz;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LAT(2), .WRITE_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .dreq(dreq[0]), .dwrite(dwrite[0]), .daddr(daddr[0]),
        .ddata(bus0), .dready_n(dready_n[0]), .dbusy(dbusy[0]), .daddr_err(daddr_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LAT(4), .WRITE_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst), .dreq(dreq[1]), .dwrite(dwrite[1]), .daddr(daddr[1]),
        .ddata(bus1), .dready_n(dready_n[1]), .dbusy(dbusy[1]), .daddr_err(daddr_err[1])
    );

    function automatic int lat_of(input int sel, input bit wr);
        if (sel == 0) return wr ? 1 : 2;
        return wr ? 3 : 4;
    endfunction

    function automatic logic [31:0] bus_of(input int sel);
        return (sel == 0) ? bus0 : bus1;
    endfunction

    function automatic int sb_size(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic checkOutput(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL u%0d %s: got %h, want %h (cycle %0d)", inst, name, act, exp, cyc);
        end
    endtask

    // An undriven bus reads as Z in a 4-state simulator and as zero in a 2-state one.
    task automatic checkReleased(input int inst, input string name, input logic [31:0] v);
        n_cmp++;
        if (!($isunknown(v) || v == 32'h0)) begin
            n_fail++;
            $display("[TB] FAIL u%0d %s: got %h, want undriven bus (cycle %0d)", inst, name, v, cyc);
        end
    endtask

    task automatic failEvent(input int inst, input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL u%0d %s: got completion strobe, want none (cycle %0d)", inst, name, cyc);
    endtask

    // Monitor: every completion strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                busy_cnt[k] = 0;
            end else begin
                if (dbusy[k]) busy_cnt[k]++;
                if (!dready_n[k]) begin
                    if (sb_size(k) == 0) begin
                        failEvent(k, "unexpected_ready");
                    end else begin
                        exp_t e;
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        checkOutput(k, "ready_cycle", 32'(cyc), 32'(e.ready_cyc));
                        checkOutput(k, "busy_cycles", 32'(busy_cnt[k]), 32'(e.lat - 1));
                        checkOutput(k, "addr_err", {31'h0, daddr_err[k]}, {31'h0, e.err});
                        if (e.is_read && e.known) checkOutput(k, "read_data", bus_of(k), e.data);
                    end
                    busy_cnt[k] = 0;
                end else begin
                    checkOutput(k, "err_outside_ready", {31'h0, daddr_err[k]}, 32'h0);
                    if (!oe[k]) checkReleased(k, "bus_outside_ready", bus_of(k));
                end
            end
        end
    end

    task automatic applyStimulus(input int sel, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                 input bit scramble, input bit keep_req, input logic [31:0] next_addr);
        exp_t e;
        bit   got;
        bit   oob;
        int   w;
        got = 1'b0;
        @(negedge clk);
        #1;
        dreq[sel]   = 1'b1;
        dwrite[sel] = wr;
        daddr[sel]  = addr;
        drv[sel]    = data;
        oe[sel]     = wr;
        oob = (addr >= 32'(DEPTH * 4));
        w   = oob ? 0 : int'(addr / 4);
        e.lat       = lat_of(sel, wr);
        e.ready_cyc = cyc + e.lat;
        e.is_read   = !wr;
        e.err       = oob;
        e.known     = oob || known[sel][w];
        e.data      = oob ? 32'h0 : mdl[sel][w];
        if (wr && !oob) begin
            mdl[sel][w]   = data;
            known[sel][w] = 1'b1;
        end
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!dready_n[sel]) begin
                got = 1'b1;
                break;
            end
            #1;
            if (scramble) begin
                daddr[sel] = $urandom;
                if (wr) drv[sel] = $urandom;
                if ($urandom_range(0, 3) == 0) dreq[sel] = 1'b0;
            end
        end
        checkOutput(sel, "ready_seen", 32'(got), 32'h1);
        #1;
        if (keep_req) begin
            daddr[sel]  = next_addr;
            dwrite[sel] = 1'b0;
            oe[sel]     = 1'b0;
        end else begin
            dreq[sel]  = 1'b0;
            oe[sel]    = 1'b0;
            daddr[sel] = $urandom;
        end
    endtask

    task automatic checkResetOutputs();
        for (int k = 0; k < 2; k++) begin
            checkOutput(k, "rst_ready_n", {31'h0, dready_n[k]}, 32'h1);
            checkOutput(k, "rst_busy", {31'h0, dbusy[k]}, 32'h0);
            checkOutput(k, "rst_addr_err", {31'h0, daddr_err[k]}, 32'h0);
            checkReleased(k, "rst_bus", bus_of(k));
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            dreq[k] = 1'b0; dwrite[k] = 1'b0; daddr[k] = 32'h0; drv[k] = 32'h0; oe[k] = 1'b0;
            busy_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);
        checkResetOutputs();
        #1 rst = 1'b0;

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                applyStimulus(k, 1'b1, 32'(i * 4), $urandom | 32'h0100_0000, 1'b0, 1'b0, 32'h0);

        applyStimulus(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h0);

        applyStimulus(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 1'b0, 32'h0);

        for (int k = 0; k < 2; k++) begin
            applyStimulus(k, 1'b1, 32'h0000_1000, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0);
            applyStimulus(k, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 32'h0);
            applyStimulus(k, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 32'h0);
        end

        // Abort a slow write mid-flight; the old word must survive.
        applyStimulus(1, 1'b1, 32'h0000_0004, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        dreq[1] = 1'b1; dwrite[1] = 1'b1; daddr[1] = 32'h4; drv[1] = 32'hAAAA_AAAA; oe[1] = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b1; dreq[1] = 1'b0; oe[1] = 1'b0;
        @(negedge clk);
        checkResetOutputs();
        @(negedge clk);
        #1 rst = 1'b0;
        applyStimulus(1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 1'b0, 32'h0);

        applyStimulus(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 1'b1, 32'h0000_000C);
        applyStimulus(0, 1'b0, 32'h0000_000C, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 1'b1, 32'h0000_000C);
        applyStimulus(1, 1'b0, 32'h0000_000C, 32'h0, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            int          sel;
            bit          wr;
            logic [31:0] addr;
            sel = int'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_1000;
            else addr = 32'(($urandom_range(0, 31) << 2) | $urandom_range(0, 3));
            applyStimulus(sel, wr, addr, $urandom, 1'b1, 1'b0, 32'h0);
        end

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                applyStimulus(k, 1'b0, 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0);

        repeat (4) @(negedge clk);
        checkOutput(0, "sb_drain", 32'(q0.size()), 32'h0);
        checkOutput(1, "sb_drain", 32'(q1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, 2..65536.
REQ-002 Parameter READ_LAT, default 2: cycles from read accept to the dready_n low cycle; range 1..15.
REQ-003 Parameter WRITE_LAT, default 1: cycles from write accept to the dready_n low cycle; range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 dreq  input  1  access request from the initiator, held high until it sees dready_n low.
REQ-007 dwrite  input  1  1 = write, 0 = read; valid while dreq is high.
REQ-008 daddr  input  32  byte address; bits [1:0] are ignored, and the word index is daddr[log2(DEPTH_WORDS)+1:2].
REQ-009 ddata  inout  32  write data from the initiator; read data driven by this block only in a read READY cycle, otherwise high-Z.
REQ-010 dready_n  output  1  active-low completion strobe, low for exactly one cycle per transaction.
REQ-011 dbusy  output  1  high while an accepted transaction is in progress, before completion.
REQ-012 daddr_err  output  1  one-cycle pulse, coincident with dready_n low, for an access to an out-of-range address.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY and READY.
REQ-014 IDLE with dreq=1 at a clock edge SHALL accept the request, latching daddr, dwrite and ddata (when dwrite=1) into internal registers.
REQ-015 On accept, the down-counter SHALL load LAT-1, where LAT is READ_LAT or WRITE_LAT selected by dwrite.
- LAT=1: next state READY.
- Otherwise: next state BUSY.
REQ-016 BUSY SHALL decrement the counter each cycle and move to READY when the counter reaches 1 (or is already 1), so that READY occurs exactly LAT cycles after the accept edge.
REQ-017 READY SHALL last one cycle, then return to IDLE unconditionally.
- Back-to-back requests therefore see one IDLE cycle between READY and the next accept.
REQ-018 dready_n SHALL be 0 only in READY; dbusy SHALL be 1 only in BUSY and in READY-pending cycles, i.e. exactly while state==BUSY.
REQ-019 A read in READY SHALL drive ddata with mem[latched index] combinationally for that cycle.
- An out-of-range read SHALL drive 32'h0000_0000.
REQ-020 A write SHALL commit the latched data to mem at the READY-cycle clock edge.
- An out-of-range write SHALL be dropped.
REQ-021 An address is out of range when daddr[31:log2(DEPTH_WORDS)+2] is non-zero; daddr_err SHALL be high in READY for such an access, otherwise 0.
REQ-022 Changes on daddr, dwrite or ddata after accept SHALL be ignored; only the latched values are used.
REQ-023 dreq falling during BUSY SHALL NOT abort the transaction: READY still occurs and a write still commits.
REQ-024 dreq held high through READY SHALL NOT start a new transaction in that same cycle; it is sampled again in IDLE.
REQ-025 ddata SHALL never be driven when dwrite latched=1 and SHALL never be driven outside READY, to avoid bus contention with the initiator.

Reset
REQ-026 rst=1 at a clock edge SHALL set the state to IDLE, the counter to 0, dready_n=1, dbusy=0, daddr_err=0, and ddata to high-Z.
REQ-027 Reset during BUSY or READY SHALL abort the transaction; a pending write SHALL NOT commit.
REQ-028 Memory contents SHALL NOT be cleared by reset; the initial contents are undefined unless preloaded by the bench.

Verification
REQ-029 Write-then-read, defaults: write 0x0000_0010 with data 0xDEAD_BEEF.
- Write: dready_n low 1 cycle after accept.
- Read of the same address: dready_n low 2 cycles after accept, with ddata=0xDEAD_BEEF in that cycle.
REQ-030 Latency sweep, READ_LAT=4 and WRITE_LAT=3.
- dbusy high for 3 and 2 cycles respectively.
- dready_n low exactly at accept+4 and accept+3.
REQ-031 Address-change robustness: change daddr and ddata every cycle while BUSY on a write to 0x20 with data 0x1234_5678.
- Only mem[8] changes, and it becomes 0x1234_5678.
REQ-032 Out-of-range access, DEPTH_WORDS=1024.
- Write to 0x0000_1000: daddr_err pulses, and no word changes.
- Read of 0x0000_1000: ddata=0, and daddr_err pulses.
REQ-033 Reset mid-write: assert rst during BUSY of a WRITE_LAT=3 write of 0xAAAA_AAAA to 0x4 holding 0x5555_5555.
- Outputs return to reset values.
- A subsequent read of 0x4 returns 0x5555_5555.
REQ-034 Back-to-back: hold dreq=1 across two reads with the address switched at dready_n low.
- Second accept occurs exactly one IDLE cycle after READY.
- No ddata drive occurs outside the two READY cycles.
